ramp_adc_capture: RTL
=====================

# ramp_adc_capture

Multi-channel single-slope ADC front end for the iCE40 LVDS comparator inputs. Holds an external ramp discharged, releases it, runs a conversion counter, and timestamps each channel's glitch-filtered comparator trip. Captured codes are streamed out over a valid/ready interface to the UART/logic-analyser side of the design. It generalises the single-channel comparator trigger to N channels, configurable width and filtering, one-shot or continuous mode, and overflow/early-trip reporting.

## Interface
- CHANNELS, 4: number of comparator inputs (1–8).
- CNT_W, 10: conversion counter and result width.
- SYNC_STAGES, 2: synchroniser flops per comparator input (≥2).
- FILT_LEN, 3: consecutive synchronised-high samples required to qualify a trip (≥1).
- DISCH_CYCLES, 16: cycles the ramp is held discharged before each conversion (≥1).
- clk  in  1  system clock (hf_osc domain).
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- continuous  in  1  1 = re-arm automatically after each drain.
- comp_in  in  CHANNELS  raw asynchronous comparator outputs (SB_IO D_IN_0).
- ramp_discharge  out  1  1 = hold external ramp at zero.
- ramp_run  out  1  1 = ramp active (gates external reference clock).
- busy  out  1  high in every state except IDLE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_chan  out  3  channel index of current result.
- res_data  out  CNT_W  captured count.
- res_flags  out  2  00 normal, 01 overflow (no trip), 10 early (high at ramp start).

## Operation
- FSM states: IDLE, DISCHARGE, RAMP, DRAIN.
- IDLE: ramp_discharge=1; start=1 → DISCHARGE.
- DISCHARGE: ramp_discharge=1 for DISCH_CYCLES cycles, counter cleared, captures and flags cleared → RAMP.
- RAMP: ramp_discharge=0, ramp_run=1; counter starts at 0, +1 per cycle.
  - A channel captures on the first rising edge of its filtered signal: data=counter, flags=00.
  - A channel whose filtered signal is already high in the first RAMP cycle captures data=0, flags=10.
  - Exit when all channels have captured, or when the counter equals 2^CNT_W−1. Untripped channels get data=all-ones and flags=01.
  - A trip in the same cycle the counter reaches max is a normal capture (flags=00).
- DRAIN: ramp_discharge=1. Results are presented in channel order 0..CHANNELS−1, one per handshake.
  - After the last accept: → DISCHARGE if continuous=1, else → IDLE.
- start is ignored outside IDLE.
- Clearing continuous mid-conversion finishes the current drain, then goes to IDLE.
- Filters run in every state. A filtered level that rises and falls again during RAMP does not re-capture.
- rst mid-operation: FSM to IDLE immediately, in-flight results discarded.
- Reset values: ramp_discharge=1, ramp_run=0, busy=0, res_valid=0, res_chan=0, res_data=0, res_flags=0, counter=0, filters/synchronisers=0.

## Timing
- start high at edge t → DISCHARGE from t+1 → first RAMP cycle at t+1+DISCH_CYCLES.
- Trip latency L = SYNC_STAGES+FILT_LEN−1. Raw comp_in first sampled high at counter value k → captured data = k+L (consumer subtracts L).
- RAMP → DRAIN one cycle after the exit condition. res_valid rises on the first DRAIN cycle.
- res_valid, res_chan, res_data and res_flags are held stable while res_valid=1 and res_ready=0.
- A transfer occurs on an edge with res_valid & res_ready. The next channel is presented the following cycle, so with res_ready held high there is one result per cycle.
- Maximum conversion length is 2^CNT_W cycles of RAMP.

## Structure
- Shared package ramp_adc_pkg holds:
  - FSM state encoding.
  - Flag constants FLAG_NORMAL=2'b00, FLAG_OVF=2'b01, FLAG_EARLY=2'b10.
- One sub-module, comp_sync_filter, instantiated per channel (SYNC_STAGES synchroniser + FILT_LEN run-length qualifier). Output: filtered level and rising-edge pulse.
- Top level contains the FSM, counter, per-channel capture registers and the drain mux.

## Test plan
All scenarios use defaults, CNT_W=8, L=4.
- Single conversion: start pulse, ch0..3 raw rise at k=10/50/100/200 → four results, data 14/54/104/204, flags 00, ch order 0..3; then busy=0 and ramp_discharge=1.
- Glitch rejection: ch2 high for 2 cycles at k=30, then steady rise at k=80 → ch2 data=84; no capture at 30–34.
- Overflow/early: ch1 held high through DISCHARGE and ch3 never trips → ch1 data=0 flags=10; ch3 data=255 flags=01; RAMP lasts 256 cycles.
- Backpressure: res_ready toggled 1-in-3 → outputs stable while stalled, exactly 4 transfers, no duplicates or drops.
- Continuous mode: continuous=1, one start → back-to-back conversions with DISCHARGE=16 cycles between them. Clearing continuous during the 2nd RAMP → 2nd drain completes, then IDLE.
- Reset mid-RAMP: rst asserted at k=60 → same cycle ramp_discharge=1, ramp_run=0, res_valid=0. After release, a fresh start yields a correct full conversion.

Source files
------------

// File: rtl/ramp_adc_pkg.sv
// Shared types for the single-slope ramp ADC capture block.
// FSM encoding and result flag codes.
package ramp_adc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISCHARGE,
    S_RAMP,
    S_DRAIN
  } state_t;

  localparam logic [1:0] FLAG_NORMAL = 2'b00;
  localparam logic [1:0] FLAG_OVF    = 2'b01;
  localparam logic [1:0] FLAG_EARLY  = 2'b10;

endpackage

// File: rtl/comp_sync_filter.sv
// Comparator synchroniser plus run-length qualifier.
// level is high once FILT_LEN consecutive synchronised samples are high.
module comp_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic comp_raw,
  output logic level,
  output logic rise
);

  localparam int RW = $clog2(FILT_LEN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RW-1:0]          run_q;
  logic                   level_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];
  // run_q counts earlier high samples, so the current one completes the run
  assign level = s && (run_q == RUN_MAX);
  assign rise  = level && !level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      run_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], comp_raw};
      level_q <= level;
      if (!s)
        run_q <= '0;
      else if (run_q != RUN_MAX)
        run_q <= run_q + 1'b1;
    end
  end

endmodule

// File: rtl/ramp_adc_capture.sv
// Multi-channel single-slope ADC front end: discharge, ramp,
// timestamp filtered comparator trips, drain codes over valid/ready.
module ramp_adc_capture
  import ramp_adc_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int CNT_W        = 10,
  parameter int SYNC_STAGES  = 2,
  parameter int FILT_LEN     = 3,
  parameter int DISCH_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                continuous,
  input  logic [CHANNELS-1:0] comp_in,
  output logic                ramp_discharge,
  output logic                ramp_run,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2:0]          res_chan,
  output logic [CNT_W-1:0]    res_data,
  output logic [1:0]          res_flags
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int DW = $clog2(DISCH_CYCLES + 1);
  localparam logic [DW-1:0] DISCH_LAST = DW'(DISCH_CYCLES - 1);
  localparam logic [2:0] LAST_CH = 3'(CHANNELS - 1);

  state_t state_q, state_d;

  logic [DW-1:0]       disch_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0]          idx_q;
  logic [CHANNELS-1:0] level, rise, trip, cap_q;
  logic [CNT_W-1:0]    data_q [CHANNELS];
  logic [1:0]          flags_q [CHANNELS];
  logic                first, at_max, xfer;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    comp_sync_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_LEN   (FILT_LEN)
    ) u_filt (
      .clk     (clk),
      .rst     (rst),
      .comp_raw(comp_in[g]),
      .level   (level[g]),
      .rise    (rise[g])
    );
  end

  // A level already high on the first ramp cycle counts as a trip
  assign first  = (cnt_q == '0);
  assign at_max = (cnt_q == CNT_MAX);
  assign trip   = first ? level : rise;
  assign xfer   = (state_q == S_DRAIN) && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    ramp_discharge = 1'b1;
    ramp_run       = 1'b0;
    busy           = 1'b1;
    res_valid      = 1'b0;
    res_chan       = '0;
    res_data       = '0;
    res_flags      = FLAG_NORMAL;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_d = S_DISCHARGE;
      end
      S_DISCHARGE: begin
        if (disch_q == DISCH_LAST)
          state_d = S_RAMP;
      end
      S_RAMP: begin
        ramp_discharge = 1'b0;
        ramp_run       = 1'b1;
        if ((&(cap_q | trip)) || at_max)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        res_valid = 1'b1;
        res_chan  = idx_q;
        for (int i = 0; i < CHANNELS; i++) begin
          if (idx_q == 3'(i)) begin
            res_data  = data_q[i];
            res_flags = flags_q[i];
          end
        end
        if (res_ready && idx_q == LAST_CH)
          state_d = continuous ? S_DISCHARGE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disch_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        data_q[i]  <= '0;
        flags_q[i] <= FLAG_NORMAL;
      end
    end else begin
      disch_q <= (state_q == S_DISCHARGE) ? disch_q + 1'b1 : '0;
      cnt_q   <= (state_q == S_RAMP) ? cnt_q + 1'b1 : '0;
      if (state_q == S_DISCHARGE) begin
        cap_q <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          data_q[i]  <= '0;
          flags_q[i] <= FLAG_NORMAL;
        end
      end
      if (state_q == S_RAMP) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (!cap_q[i]) begin
            if (trip[i]) begin
              cap_q[i]   <= 1'b1;
              data_q[i]  <= cnt_q;
              flags_q[i] <= first ? FLAG_EARLY : FLAG_NORMAL;
            end else if (at_max) begin
              cap_q[i]   <= 1'b1;
              data_q[i]  <= CNT_MAX;
              flags_q[i] <= FLAG_OVF;
            end
          end
        end
      end
      if (xfer)
        idx_q <= (idx_q == LAST_CH) ? '0 : idx_q + 1'b1;
    end
  end

endmodule
